// File: rtl/arbiter_pkg.sv
// Shared state encoding and default sizing for the channel arbiter and its
// round-robin picker.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arbState_e;

  localparam int DefaultNumPorts  = 4;
  localparam int DefaultDataWidth = 32;
  localparam int DefaultBurstLen  = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: returns the first requesting port at or
// after the pointer, wrapping modulo NUM_PORTS.
module rr_picker
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DefaultNumPorts,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IDX_W-1:0]     pointer,
  output logic [IDX_W-1:0]     winner,
  output logic                 found
);

  // Exact modulo wrap so non-power-of-two port counts never index a ghost port.
  function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] base,
                                               input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return IDX_W'(sum);
  endfunction

  // Scanning from the farthest offset back to zero lets the nearest requester win.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (request[wrapIdx(pointer, k)]) begin
        winner = wrapIdx(pointer, k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_arbiter.sv
// Burst-locking round-robin arbiter funnelling NUM_PORTS requesters into a
// single registered output stage with full-throughput handshaking.
module channel_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = DefaultNumPorts,
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int BURST_LEN  = DefaultBurstLen
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] receive_data,
  input  logic [NUM_PORTS-1:0]            receive_request,
  output logic [NUM_PORTS-1:0]            receive_valid,
  output logic [DATA_WIDTH-1:0]           send_data,
  output logic                            send_request,
  input  logic                            send_valid,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LastCnt = CW'(BURST_LEN);

  arbState_e             state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rrPtr_q, rrPtr_d;
  logic [CW-1:0]         burstCnt_q, burstCnt_d;
  logic [DATA_WIDTH-1:0] sendData_q;
  logic                  sendFull_q;

  logic                  space;
  logic [IW-1:0]         pickIdx;
  logic                  pickFound;
  logic                  accept;
  logic [IW-1:0]         acceptIdx;
  logic [IW-1:0]         grantIdx;
  logic [DATA_WIDTH-1:0] acceptWord;

  function automatic logic [IW-1:0] nextPort(input logic [IW-1:0] p);
    if (int'(p) == NUM_PORTS - 1) return '0;
    return p + IW'(1);
  endfunction

  rr_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IW)
  ) u_picker (
    .request(receive_request),
    .pointer(rrPtr_q),
    .winner (pickIdx),
    .found  (pickFound)
  );

  assign space      = !sendFull_q || send_valid;
  assign acceptWord = receive_data[int'(acceptIdx)*DATA_WIDTH +: DATA_WIDTH];

  // An owner dropping its request ends the burst even while the output is stalled.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rrPtr_d    = rrPtr_q;
    burstCnt_d = burstCnt_q;
    accept     = 1'b0;
    acceptIdx  = owner_q;
    grantIdx   = '0;
    unique case (state_q)
      IDLE: begin
        if (space && pickFound) begin
          accept     = 1'b1;
          acceptIdx  = pickIdx;
          grantIdx   = pickIdx;
          burstCnt_d = CW'(1);
          if (BURST_LEN == 1) begin
            rrPtr_d = nextPort(pickIdx);
          end else begin
            state_d = LOCK;
            owner_d = pickIdx;
          end
        end
      end
      LOCK: begin
        grantIdx = owner_q;
        if (!receive_request[owner_q]) begin
          state_d = IDLE;
          rrPtr_d = nextPort(owner_q);
        end else if (space) begin
          accept     = 1'b1;
          burstCnt_d = burstCnt_q + CW'(1);
          if (burstCnt_q + CW'(1) == LastCnt) begin
            state_d = IDLE;
            rrPtr_d = nextPort(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the combinational outputs so nothing leaks out while held.
  assign receive_valid = (reset && accept) ? (NUM_PORTS'(1) << acceptIdx) : '0;
  assign grant_id      = reset ? grantIdx : '0;
  assign busy          = (state_q == LOCK);
  assign send_request  = sendFull_q;
  assign send_data     = sendData_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rrPtr_q    <= '0;
      burstCnt_q <= '0;
      sendData_q <= '0;
      sendFull_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rrPtr_q    <= rrPtr_d;
      burstCnt_q <= burstCnt_d;
      if (accept) begin
        sendData_q <= acceptWord;
        sendFull_q <= 1'b1;
      end else if (send_valid) begin
        sendFull_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed, table-driven bench for channel_arbiter: a default 4-port instance
// plus a 3-port single-word-burst instance.
module tb_channel_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;

  typedef struct {
    logic        doReset;
    logic [3:0]  req;
    logic        sv;
    logic [3:0]  expRv;
    logic [1:0]  expGrant;
    logic        expBusy;
    logic        expSendReq;
    logic [31:0] expData;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NP*DW-1:0]  recvData;
  logic [NP-1:0]     recvReq;
  logic [NP-1:0]     recvValid;
  logic [DW-1:0]     sendData;
  logic              sendReq;
  logic              sendValid;
  logic [1:0]        grantId;
  logic              busy;

  logic [3*DW-1:0]   bData;
  logic [2:0]        bReq;
  logic [2:0]        bValid;
  logic [DW-1:0]     bSendData;
  logic              bSendReq;
  logic              bSendValid;
  logic [1:0]        bGrant;
  logic              bBusy;

  int testsRun    = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  channel_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .BURST_LEN(4)) dutA (
    .clk            (clk),
    .reset          (reset),
    .receive_data   (recvData),
    .receive_request(recvReq),
    .receive_valid  (recvValid),
    .send_data      (sendData),
    .send_request   (sendReq),
    .send_valid     (sendValid),
    .grant_id       (grantId),
    .busy           (busy)
  );

  channel_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(32), .BURST_LEN(1)) dutB (
    .clk            (clk),
    .reset          (reset),
    .receive_data   (bData),
    .receive_request(bReq),
    .receive_valid  (bValid),
    .send_data      (bSendData),
    .send_request   (bSendReq),
    .send_valid     (bSendValid),
    .grant_id       (bGrant),
    .busy           (bBusy)
  );

  function automatic logic [31:0] wordA(input int port);
    return 32'hA5A5_0000 + 32'(port);
  endfunction

  function automatic logic [31:0] wordB(input int port);
    return 32'hB0B0_0000 + 32'(port);
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] req, input logic sv,
                              input logic [3:0] rv, input logic [1:0] g, input logic b,
                              input logic sr, input logic [31:0] d);
    vec_t v;
    v.doReset = r; v.req = req; v.sv = sv; v.expRv = rv; v.expGrant = g;
    v.expBusy = b; v.expSendReq = sr; v.expData = d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic sv);
    @(negedge clk);
    recvReq   = req;
    sendValid = sv;
    #1;
  endtask

  // Holds reset with every port requesting to prove the outputs stay gated.
  task automatic doReset();
    reset      = 1'b0;
    recvReq    = 4'hF;
    sendValid  = 1'b1;
    bReq       = 3'b000;
    bSendValid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset.rv",      32'(recvValid), 32'h0);
    checkOutput("reset.grant",   32'(grantId),   32'h0);
    checkOutput("reset.busy",    32'(busy),      32'h0);
    checkOutput("reset.sendReq", 32'(sendReq),   32'h0);
    checkOutput("reset.data",    sendData,       32'h0);
    recvReq = 4'h0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < NP; i++) recvData[i*DW +: DW] = wordA(i);
    for (int i = 0; i < 3; i++)  bData[i*DW +: DW]    = wordB(i);
    recvReq    = '0;
    sendValid  = 1'b0;
    bReq       = '0;
    bSendValid = 1'b0;

    // All four ports requesting: bursts of four, rotating 0 -> 1 -> 2.
    vecs.push_back(mk(1, 4'hF, 1, 4'h1, 2'd0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 4'hF, 1, 4'h1, 2'd0, 1, 1, wordA(0)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h1, 2'd0, 1, 1, wordA(0)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h1, 2'd0, 1, 1, wordA(0)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h2, 2'd1, 0, 1, wordA(0)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h2, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h2, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h2, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h4, 2'd2, 0, 1, wordA(1)));
    vecs.push_back(mk(0, 4'hF, 1, 4'h4, 2'd2, 1, 1, wordA(2)));
    // Port 2 alone for three words, then drops; rotation resumes at port 3.
    vecs.push_back(mk(1, 4'h4, 1, 4'h4, 2'd2, 0, 0, 32'h0));
    vecs.push_back(mk(0, 4'h4, 1, 4'h4, 2'd2, 1, 1, wordA(2)));
    vecs.push_back(mk(0, 4'h4, 1, 4'h4, 2'd2, 1, 1, wordA(2)));
    vecs.push_back(mk(0, 4'h0, 1, 4'h0, 2'd2, 1, 1, wordA(2)));
    vecs.push_back(mk(0, 4'h9, 1, 4'h8, 2'd3, 0, 0, wordA(2)));
    vecs.push_back(mk(0, 4'h9, 1, 4'h8, 2'd3, 1, 1, wordA(3)));
    // Port 1 stalled for five cycles; the burst count survives the stall.
    vecs.push_back(mk(1, 4'h2, 1, 4'h2, 2'd1, 0, 0, 32'h0));
    for (int s = 0; s < 5; s++) vecs.push_back(mk(0, 4'h2, 0, 4'h0, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 2'd1, 1, 1, wordA(1)));
    vecs.push_back(mk(0, 4'h2, 1, 4'h2, 2'd1, 0, 1, wordA(1)));

    foreach (vecs[i]) begin
      if (vecs[i].doReset) doReset();
      applyStimulus(vecs[i].req, vecs[i].sv);
      checkOutput($sformatf("vec%0d.rv", i),      32'(recvValid), 32'(vecs[i].expRv));
      checkOutput($sformatf("vec%0d.grant", i),   32'(grantId),   32'(vecs[i].expGrant));
      checkOutput($sformatf("vec%0d.busy", i),    32'(busy),      32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d.sendReq", i), 32'(sendReq),   32'(vecs[i].expSendReq));
      checkOutput($sformatf("vec%0d.data", i),    sendData,       vecs[i].expData);
    end

    // Asynchronous reset mid-burst with a word pending, then a clean restart.
    doReset();
    applyStimulus(4'b0110, 1'b1);
    checkOutput("midrst.firstRv", 32'(recvValid), 32'h2);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("midrst.lockBusy", 32'(busy), 32'h1);
    @(posedge clk);
    #2;
    checkOutput("midrst.preBusy", 32'(busy),    32'h1);
    checkOutput("midrst.preReq",  32'(sendReq), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("midrst.sendReq", 32'(sendReq),   32'h0);
    checkOutput("midrst.data",    sendData,       32'h0);
    checkOutput("midrst.busy",    32'(busy),      32'h0);
    checkOutput("midrst.grant",   32'(grantId),   32'h0);
    checkOutput("midrst.rv",      32'(recvValid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst.relRv",    32'(recvValid), 32'h2);
    checkOutput("midrst.relGrant", 32'(grantId),   32'h1);
    checkOutput("midrst.relBusy",  32'(busy),      32'h0);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("midrst.nextBusy", 32'(busy), 32'h1);
    checkOutput("midrst.nextData", sendData,  wordA(1));
    recvReq = 4'h0;

    // Three ports, single-word bursts: strict 0,1,2 rotation, never locked.
    doReset();
    for (int k = 0; k < 6; k++) begin
      logic [2:0]  expRv;
      logic [31:0] expData;
      @(negedge clk);
      bReq       = 3'b111;
      bSendValid = 1'b1;
      #1;
      expRv   = 3'(1 << (k % 3));
      expData = (k == 0) ? 32'h0 : wordB((k - 1) % 3);
      checkOutput($sformatf("b%0d.grant", k),   32'(bGrant),   32'(k % 3));
      checkOutput($sformatf("b%0d.rv", k),      32'(bValid),   32'(expRv));
      checkOutput($sformatf("b%0d.busy", k),    32'(bBusy),    32'h0);
      checkOutput($sformatf("b%0d.sendReq", k), 32'(bSendReq), (k == 0) ? 32'h0 : 32'h1);
      checkOutput($sformatf("b%0d.data", k),    bSendData,     expData);
    end
    bReq = 3'b000;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
